// File: rtl/acq_pkg.sv
// Shared constants and state encoding for the sample acquisition sequencer.
// Defaults match the 1024 x 14 sample RAM instance.
package acq_pkg;

  localparam int DEF_N_ENTRIES = 1024;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_BIT_W     = 14;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_PRETRIG  = 3'd1;
  localparam logic [ST_W-1:0] ST_ARMED    = 3'd2;
  localparam logic [ST_W-1:0] ST_POSTTRIG = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd4;
  localparam logic [ST_W-1:0] ST_READOUT  = 3'd5;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = ST_IDLE,
    S_PRETRIG  = ST_PRETRIG,
    S_ARMED    = ST_ARMED,
    S_POSTTRIG = ST_POSTTRIG,
    S_DONE     = ST_DONE,
    S_READOUT  = ST_READOUT
  } acq_state_e;

endpackage

// File: rtl/sample_acq_ctrl_if.sv
// Sample RAM port bundle: the sequencer is master, the RAM is slave.
// The RAM samples address/enables on the falling clock edge.
interface sample_acq_ctrl_if #(
  parameter int ADDR_W = acq_pkg::DEF_ADDR_W,
  parameter int BIT_W  = acq_pkg::DEF_BIT_W
);

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [BIT_W-1:0]  ram_data_wr;
  logic [BIT_W-1:0]  ram_data_rd;

  modport master (
    output ram_addr,
    output ram_wr_en,
    output ram_rd_en,
    output ram_data_wr,
    input  ram_data_rd
  );

  modport slave (
    input  ram_addr,
    input  ram_wr_en,
    input  ram_rd_en,
    input  ram_data_wr,
    output ram_data_rd
  );

endinterface

// File: rtl/acq_rd_pipe.sv
// Readout sequencing: rd_ptr/rd_cnt walk the record oldest-first and the
// RAM read data is registered into rd_data/rd_valid/rd_last one cycle later.
module acq_rd_pipe #(
  parameter int N_ENTRIES = acq_pkg::DEF_N_ENTRIES,
  parameter int ADDR_W    = $clog2(N_ENTRIES),
  parameter int BIT_W     = acq_pkg::DEF_BIT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_done,
  input  logic              in_readout,
  input  logic              flush,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] start_ptr,
  input  logic [BIT_W-1:0]  ram_data_rd,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_issue,
  output logic              rd_full,
  output logic [BIT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_last
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(N_ENTRIES);

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] cur_ptr;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   cur_cnt;
  logic              active;
  logic              is_last;

  // DONE presents the record start so a request there is served at once
  assign active   = in_done | in_readout;
  assign cur_ptr  = in_done ? start_ptr : rd_ptr;
  assign cur_cnt  = in_done ? '0 : rd_cnt;
  assign rd_issue = rd_req & active & (cur_cnt != FULL);
  assign is_last  = cur_cnt == (FULL - 1'b1);
  assign rd_full  = in_readout & (rd_cnt == FULL);
  assign rd_addr  = cur_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (active) begin
        rd_ptr <= cur_ptr + {{(ADDR_W-1){1'b0}}, rd_issue};
        rd_cnt <= cur_cnt + {{ADDR_W{1'b0}}, rd_issue};
      end
      if (rd_issue)
        rd_data <= ram_data_rd;
      rd_valid <= rd_issue & ~flush;
      rd_last  <= rd_issue & ~flush & is_last;
    end
  end

endmodule

// File: rtl/sample_acq_ctrl.sv
// Acquisition sequencer: circular capture with pre-trigger depth into the
// sample RAM, then time-ordered readout of the frozen record.
module sample_acq_ctrl #(
  parameter int N_ENTRIES = acq_pkg::DEF_N_ENTRIES,
  parameter int ADDR_W    = $clog2(N_ENTRIES),
  parameter int BIT_W     = acq_pkg::DEF_BIT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic [BIT_W-1:0]  sample_in,
  input  logic              sample_valid,
  input  logic              trig_in,
  sample_acq_ctrl_if.master ram,
  input  logic              rd_req,
  output logic [BIT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  import acq_pkg::*;

  localparam logic [ADDR_W:0] N_CNT = (ADDR_W+1)'(N_ENTRIES);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  acq_state_e        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] plen;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   post;
  logic              capturing;
  logic              in_done;
  logic              in_readout;
  logic              wr;
  logic              arm_ok;
  logic              flush;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_issue;
  logic              rd_full;

  assign capturing = (state == S_PRETRIG) |
                     (state == S_ARMED) |
                     (state == S_POSTTRIG);
  assign in_done    = state == S_DONE;
  assign in_readout = state == S_READOUT;
  assign wr         = capturing & sample_valid;
  assign arm_ok     = arm & ((state == S_IDLE) | in_done);
  assign flush      = abort | (arm & in_done);
  assign post       = N_CNT - {1'b0, plen};
  assign start_ptr  = trig_addr - plen;

  assign busy = capturing;
  assign done = in_done | in_readout;

  assign ram.ram_addr    = done ? rd_addr : wr_ptr;
  assign ram.ram_wr_en   = wr;
  assign ram.ram_rd_en   = rd_issue;
  assign ram.ram_data_wr = sample_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      plen      <= '0;
      cnt       <= '0;
      trig_addr <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (abort) begin
        state <= S_IDLE;
      end else if (arm_ok) begin
        // pretrig_len is ADDR_W wide, so it never exceeds N_ENTRIES-1
        plen  <= pretrig_len;
        cnt   <= '0;
        state <= (pretrig_len == '0) ? S_ARMED : S_PRETRIG;
      end else begin
        unique case (state)
          S_PRETRIG: if (wr) begin
            cnt <= cnt + 1'b1;
            if ((cnt + 1'b1) == {1'b0, plen})
              state <= S_ARMED;
          end
          S_ARMED: if (wr && trig_in) begin
            trig_addr <= wr_ptr;
            cnt       <= post - 1'b1;
            state     <= (post == ONE) ? S_DONE : S_POSTTRIG;
          end
          S_POSTTRIG: if (wr) begin
            cnt <= cnt - 1'b1;
            if (cnt == ONE)
              state <= S_DONE;
          end
          S_DONE: if (rd_req)
            state <= S_READOUT;
          S_READOUT: if (rd_full)
            state <= S_DONE;
          default: ;
        endcase
      end
    end
  end

  acq_rd_pipe #(
    .N_ENTRIES (N_ENTRIES),
    .ADDR_W    (ADDR_W),
    .BIT_W     (BIT_W)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_done     (in_done),
    .in_readout  (in_readout),
    .flush       (flush),
    .rd_req      (rd_req),
    .start_ptr   (start_ptr),
    .ram_data_rd (ram.ram_data_rd),
    .rd_addr     (rd_addr),
    .rd_issue    (rd_issue),
    .rd_full     (rd_full),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last)
  );

endmodule

// File: tb/tb_sample_acq_ctrl.sv
// Directed bench for sample_acq_ctrl with a 16-entry negedge RAM model.
// Sample data = record tag * 256 + write address.
module tb_sample_acq_ctrl;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int BW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pretrig_len = '0;
  logic [BW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          trig_in = 1'b0;
  logic          rd_req = 1'b0;
  logic [BW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;

  int checks = 0;
  int errors = 0;
  int wp = 0;
  int rec = 0;

  logic [BW-1:0] mem [N];

  always #5 clk = ~clk;

  sample_acq_ctrl_if #(.ADDR_W(AW), .BIT_W(BW)) ram_bus ();

  sample_acq_ctrl #(
    .N_ENTRIES (N),
    .ADDR_W    (AW),
    .BIT_W     (BW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .pretrig_len  (pretrig_len),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_in      (trig_in),
    .ram          (ram_bus),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .busy         (busy),
    .done         (done),
    .trig_addr    (trig_addr)
  );

  always @(negedge clk) begin
    checks++;
    if (ram_bus.ram_wr_en === 1'b1 && ram_bus.ram_rd_en === 1'b1) begin
      errors++;
      $display("FAIL ram_excl wr_en=1 rd_en=1 required not both");
    end
    if (ram_bus.ram_wr_en === 1'b1)
      mem[ram_bus.ram_addr] <= ram_bus.ram_data_wr;
    if (ram_bus.ram_rd_en === 1'b1)
      ram_bus.ram_data_rd <= mem[ram_bus.ram_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input bit trig);
    sample_valid = 1'b1;
    trig_in = trig;
    sample_in = BW'(rec * 256 + wp);
    #1;
    checks++;
    if (ram_bus.ram_wr_en !== 1'b1 || ram_bus.ram_addr !== AW'(wp)) begin
      errors++;
      $display("FAIL write wr_en=%b addr=%0d required wr_en=1 addr=%0d",
               ram_bus.ram_wr_en, ram_bus.ram_addr, wp);
    end
    tick();
    sample_valid = 1'b0;
    trig_in = 1'b0;
    wp = (wp + 1) % N;
  endtask

  task automatic do_arm(input int plen);
    arm = 1'b1;
    pretrig_len = AW'(plen);
    tick();
    arm = 1'b0;
    rec++;
    checks++;
    if (busy !== (plen != 0 || 1'b1) || done !== 1'b0) begin
      errors++;
      $display("FAIL arm busy=%b done=%b required busy=1 done=0", busy, done);
    end
  endtask

  task automatic finish_capture(input int n_writes);
    for (int i = 0; i < n_writes; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL capture_busy w=%0d busy=%b done=%b required 1/0",
                 i, busy, done);
      end
      write_sample(1'b0);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL capture_done busy=%b done=%b required 0/1", busy, done);
    end
  endtask

  task automatic readout_cont(input int start);
    logic [BW-1:0] exp;
    for (int i = 0; i < N; i++) begin
      rd_req = 1'b1;
      tick();
      exp = BW'(rec * 256 + (start + i) % N);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp || rd_last !== (i == N - 1)) begin
        errors++;
        $display("FAIL readout i=%0d valid=%b data=%h last=%b required 1 %h %b",
                 i, rd_valid, rd_data, rd_last, exp, (i == N - 1));
      end
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL readout_end valid=%b done=%b busy=%b required 0 1 0",
               rd_valid, done, busy);
    end
  endtask

  task automatic test_reset;
    sample_valid = 1'b1;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 ||
        rd_last !== 1'b0 || trig_addr !== '0) begin
      errors++;
      $display("FAIL reset_out busy=%b done=%b valid=%b last=%b trig=%0d required zeros",
               busy, done, rd_valid, rd_last, trig_addr);
    end
    checks++;
    if (ram_bus.ram_wr_en !== 1'b0 || ram_bus.ram_rd_en !== 1'b0 ||
        ram_bus.ram_addr !== '0) begin
      errors++;
      $display("FAIL reset_ram wr=%b rd=%b addr=%0d required 0 0 0",
               ram_bus.ram_wr_en, ram_bus.ram_rd_en, ram_bus.ram_addr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_bus.ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL idle busy=%b done=%b wr=%b required 0 0 0",
               busy, done, ram_bus.ram_wr_en);
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_capture;
    do_arm(4);
    for (int i = 0; i < 10; i++)
      write_sample(i == 9);
    checks++;
    if (trig_addr !== AW'(9)) begin
      errors++;
      $display("FAIL capture_trig trig_addr=%0d required 9", trig_addr);
    end
    finish_capture(11);
    readout_cont(5);
  endtask

  task automatic test_readout_toggle;
    logic [BW-1:0] exp;
    for (int i = 0; i < N; i++) begin
      rd_req = 1'b1;
      tick();
      exp = BW'(rec * 256 + (5 + i) % N);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp || rd_last !== (i == N - 1)) begin
        errors++;
        $display("FAIL toggle i=%0d valid=%b data=%h last=%b required 1 %h %b",
                 i, rd_valid, rd_data, rd_last, exp, (i == N - 1));
      end
      rd_req = 1'b0;
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL toggle_gap i=%0d valid=%b required 0", i, rd_valid);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_end done=%b valid=%b required 1 0", done, rd_valid);
    end
  endtask

  task automatic test_pretrig_zero;
    do_arm(0);
    write_sample(1'b1);
    checks++;
    if (trig_addr !== AW'(5)) begin
      errors++;
      $display("FAIL pz_trig trig_addr=%0d required 5", trig_addr);
    end
    finish_capture(15);
    readout_cont(5);
  endtask

  task automatic test_early_trig;
    do_arm(4);
    for (int i = 0; i < 4; i++)
      write_sample(i < 3);
    write_sample(1'b0);
    write_sample(1'b1);
    checks++;
    if (trig_addr !== AW'(10)) begin
      errors++;
      $display("FAIL early_trig trig_addr=%0d required 10", trig_addr);
    end
    finish_capture(11);
    readout_cont(6);
  endtask

  task automatic test_abort_posttrig;
    do_arm(4);
    for (int i = 0; i < 4; i++)
      write_sample(1'b0);
    write_sample(1'b1);
    for (int i = 0; i < 3; i++)
      write_sample(1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_post busy=%b done=%b required 0 0", busy, done);
    end
    sample_valid = 1'b1;
    #1;
    checks++;
    if (ram_bus.ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_wr wr_en=%b required 0", ram_bus.ram_wr_en);
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_wrap;
    do_arm(4);
    for (int i = 0; i < 6; i++)
      write_sample(1'b0);
    write_sample(1'b1);
    checks++;
    if (trig_addr !== AW'(4)) begin
      errors++;
      $display("FAIL wrap_trig trig_addr=%0d required 4", trig_addr);
    end
    finish_capture(11);
    readout_cont(0);
  endtask

  task automatic test_abort_readout;
    for (int i = 0; i < 2; i++) begin
      rd_req = 1'b1;
      tick();
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL abrd_pre i=%0d valid=%b required 1", i, rd_valid);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abrd valid=%b done=%b required 0 0", rd_valid, done);
    end
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abrd_after valid=%b busy=%b done=%b required 0 0 0",
               rd_valid, busy, done);
    end
  endtask

  task automatic test_arm_abort;
    arm = 1'b1;
    abort = 1'b1;
    pretrig_len = AW'(4);
    tick();
    arm = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL arm_abort busy=%b done=%b required 0 0", busy, done);
    end
    sample_valid = 1'b1;
    #1;
    checks++;
    if (ram_bus.ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL arm_abort_wr wr_en=%b required 0", ram_bus.ram_wr_en);
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset_readout;
    do_arm(0);
    write_sample(1'b1);
    finish_capture(15);
    rd_req = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== BW'(rec * 256)) begin
      errors++;
      $display("FAIL rstrd_pre valid=%b data=%h required 1 %h",
               rd_valid, rd_data, BW'(rec * 256));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0 || trig_addr !== '0) begin
      errors++;
      $display("FAIL rst_async valid=%b done=%b trig=%0d required 0 0 0",
               rd_valid, done, trig_addr);
    end
    rd_req = 1'b0;
    #2;
    rst_n = 1'b1;
    wp = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after busy=%b done=%b valid=%b required 0 0 0",
               busy, done, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_readout_toggle();
    test_pretrig_zero();
    test_early_trig();
    test_abort_posttrig();
    test_wrap();
    test_abort_readout();
    test_arm_abort();
    test_reset_readout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
